dragon_head_ctrl: RTL

//  Upstream driver for the dragon body-segment queue. Chases the player on a 16x16 tile grid, one tile step per

---
 rtl/dragon_head_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dragon_head_ctrl.sv
// Dragon head controller: chases the player one tile per MOVE_PERIOD frames, owns the
// dragon length and turns heal/hit requests into single-clock grow/shrink codes.
module dragon_head_ctrl #(
  parameter int         MOVE_PERIOD = 20,
  parameter int         INIT_LEN    = 3,
  parameter logic [3:0] START_X     = 4'd0,
  parameter logic [3:0] START_Y     = 4'd0,
  parameter logic [1:0] START_DIR   = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  input  logic [7:0] player_pos,
  input  logic       heal_req,
  input  logic       hit_req,
  output logic [9:0] OrienAndPositon,
  output logic [5:0] movement_counter,
  output logic [1:0] States,
  output logic [2:0] dragon_len,
  output logic       dead
);

  typedef enum logic [1:0] {ST_GROW, ST_RUN, ST_DEAD} fsm_t;

  localparam logic [1:0] C_MOVE   = 2'b00;
  localparam logic [1:0] C_HEAL   = 2'b01;
  localparam logic [1:0] C_HIT    = 2'b10;
  localparam logic [1:0] C_IDLE   = 2'b11;
  localparam logic [5:0] CNT_LAST = 6'(MOVE_PERIOD - 1);
  localparam logic [2:0] LEN_INIT = 3'(INIT_LEN);
  localparam logic [2:0] LEN_MAX  = 3'd7;

  fsm_t       fsm_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic [1:0] dir_q, dir_d;
  logic [3:0] hx_q, hx_d, hy_q, hy_d;
  logic [5:0] cnt_q;
  logic [1:0] code_q, code_d;
  logic [2:0] len_q, len_d;
  logic       dead_q;
  logic       pend_heal_q, pend_hit_q;
  logic       clr_heal, clr_hit;
  logic       tick, step_now;

  logic signed [4:0] dx_s, dy_s;
  logic [3:0]        adx, ady;

  function automatic logic [2:0] len_inc(input logic [2:0] v);
    return (v == LEN_MAX) ? LEN_MAX : v + 3'd1;
  endfunction

  function automatic logic [2:0] len_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic [3:0] mag4(input logic signed [4:0] v);
    return (v < 0) ? 4'(-v) : 4'(v);
  endfunction

  assign tick     = vs_s2_q & ~vs_s3_q;
  assign step_now = tick & enable & (cnt_q == CNT_LAST);

  assign dx_s = $signed({1'b0, player_pos[7:4]}) - $signed({1'b0, hx_q});
  assign dy_s = $signed({1'b0, player_pos[3:0]}) - $signed({1'b0, hy_q});
  assign adx  = mag4(dx_s);
  assign ady  = mag4(dy_s);

  // Chase step: the larger axis distance wins, ties go to X; on target nothing moves.
  always_comb begin
    dir_d = dir_q;
    hx_d  = hx_q;
    hy_d  = hy_q;
    if (adx >= ady && adx != 4'd0) begin
      if (dx_s > 0) begin
        hx_d  = hx_q + 4'd1;
        dir_d = 2'b01;
      end else begin
        hx_d  = hx_q - 4'd1;
        dir_d = 2'b11;
      end
    end else if (ady != 4'd0) begin
      if (dy_s > 0) begin
        hy_d  = hy_q + 4'd1;
        dir_d = 2'b10;
      end else begin
        hy_d  = hy_q - 4'd1;
        dir_d = 2'b00;
      end
    end
  end

  // One code per clock: hit beats heal beats move; a heal at full length is dropped silently.
  always_comb begin
    code_d   = C_IDLE;
    len_d    = len_q;
    clr_hit  = 1'b0;
    clr_heal = 1'b0;
    if (pend_hit_q) begin
      clr_hit = 1'b1;
      if (len_q != 3'd0) begin
        code_d = C_HIT;
        len_d  = len_dec(len_q);
      end
    end else if (pend_heal_q) begin
      clr_heal = 1'b1;
      if (len_q != LEN_MAX) begin
        code_d = C_HEAL;
        len_d  = len_inc(len_q);
      end
    end else if (step_now) begin
      code_d = C_MOVE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= ST_GROW;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      dir_q       <= START_DIR;
      hx_q        <= START_X;
      hy_q        <= START_Y;
      cnt_q       <= 6'd0;
      code_q      <= C_IDLE;
      len_q       <= 3'd0;
      dead_q      <= 1'b0;
      pend_heal_q <= 1'b0;
      pend_hit_q  <= 1'b0;
    end else begin
      vs_s1_q <= vsync;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
      case (fsm_q)
        ST_GROW: begin
          pend_heal_q <= pend_heal_q | heal_req;
          pend_hit_q  <= pend_hit_q | hit_req;
          code_q      <= C_HEAL;
          len_q       <= len_inc(len_q);
          cnt_q       <= 6'd0;
          if (3'(len_q + 3'd1) == LEN_INIT) fsm_q <= ST_RUN;
        end
        ST_RUN: begin
          if (len_q == 3'd0) begin
            fsm_q       <= ST_DEAD;
            dead_q      <= 1'b1;
            code_q      <= C_IDLE;
            pend_heal_q <= 1'b0;
            pend_hit_q  <= 1'b0;
          end else begin
            code_q      <= code_d;
            len_q       <= len_d;
            pend_heal_q <= (pend_heal_q | heal_req) & ~clr_heal;
            pend_hit_q  <= (pend_hit_q | hit_req) & ~clr_hit;
            if (tick && enable) begin
              if (cnt_q == CNT_LAST) begin
                cnt_q <= 6'd0;
                dir_q <= dir_d;
                hx_q  <= hx_d;
                hy_q  <= hy_d;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
        end
        default: begin
          code_q      <= C_IDLE;
          pend_heal_q <= 1'b0;
          pend_hit_q  <= 1'b0;
        end
      endcase
    end
  end

  assign OrienAndPositon  = {dir_q, hx_q, hy_q};
  assign movement_counter = cnt_q;
  assign States           = code_q;
  assign dragon_len       = len_q;
  assign dead             = dead_q;

endmodule
